// File: rtl/lsu_dccm_banked_mem.sv
// Banked DCCM data array: NUM_BANKS word-interleaved single-port banks, one write and one lo/hi read per
// cycle, 1-entry write buffer for read/write bank conflicts. Option macro: LSU_DCCM_WBUF_BYPASS_EN.
module lsu_dccm_banked_mem #(
  parameter int NUM_BANKS  = 8,
  parameter int BANK_DEPTH = 2048,
  parameter int DATA_WIDTH = 39,
  parameter int BYTE_WIDTH = 4,
  parameter int ADDR_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  rd_ready,
  input  logic [ADDR_BITS-1:0]  rd_addr_lo,
  input  logic [ADDR_BITS-1:0]  rd_addr_hi,
  output logic [DATA_WIDTH-1:0] rd_data_lo,
  output logic [DATA_WIDTH-1:0] rd_data_hi,
  output logic                  rd_valid
);
  localparam int WB  = $clog2(BYTE_WIDTH);
  localparam int BB  = $clog2(NUM_BANKS);
  localparam int IB  = $clog2(BANK_DEPTH);
  localparam int WAW = ADDR_BITS - WB;

  typedef logic [BB-1:0]         bank_t;
  typedef logic [IB-1:0]         idx_t;
  typedef logic [WAW-1:0]        word_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  word_t lo_word, hi_word, wr_word, wbuf_word;
  bank_t lo_bank, hi_bank, wr_bank, wbuf_bank, w_bank, lo_sel, hi_sel;
  idx_t  lo_idx, hi_idx, wr_idx, wbuf_idx, w_idx;
  data_t wbuf_data, w_data;
  data_t bank_dout [NUM_BANKS];
  logic  wbuf_valid, rd_acc, wr_acc, wr_to_buf, wr_direct, drain, we_any, hit_lo, hit_hi;
  logic [NUM_BANKS-1:0] rd_mask, we_mask;
  logic  unused_bits;

  assign unused_bits = ^{wr_addr[WB-1:0], rd_addr_lo[WB-1:0], rd_addr_hi[WB-1:0]};

  assign lo_word   = rd_addr_lo[ADDR_BITS-1:WB];
  assign hi_word   = rd_addr_hi[ADDR_BITS-1:WB];
  assign wr_word   = wr_addr[ADDR_BITS-1:WB];
  assign lo_bank   = lo_word[BB-1:0];
  assign hi_bank   = hi_word[BB-1:0];
  assign wr_bank   = wr_word[BB-1:0];
  assign wbuf_bank = wbuf_word[BB-1:0];
  assign lo_idx    = lo_word[WAW-1:BB];
  assign hi_idx    = hi_word[WAW-1:BB];
  assign wr_idx    = wr_word[WAW-1:BB];
  assign wbuf_idx  = wbuf_word[WAW-1:BB];

  assign hit_lo = wbuf_valid && (lo_word == wbuf_word);
  assign hit_hi = wbuf_valid && (hi_word == wbuf_word);

  assign wr_ready = ~freeze & ~wbuf_valid;
`ifdef LSU_DCCM_WBUF_BYPASS_EN
  assign rd_ready = ~freeze;
`else
  // A read of the buffered word waits one cycle; with its bank idle the buffer drains meanwhile.
  assign rd_ready = ~freeze & ~(hit_lo | hit_hi);
`endif

  assign rd_acc = rd_en & rd_ready;
  assign wr_acc = wr_en & wr_ready;

  // NOTE: always_comb uses blocking '=' and assigns every output a default first, so no latch is inferred.
  always_comb begin
    rd_mask = '0;
    if (rd_acc) begin
      rd_mask[lo_bank] = 1'b1;
      rd_mask[hi_bank] = 1'b1;
    end
  end

  // The read owns its banks; a conflicting write parks in the buffer. Drain and new writes never coexist.
  assign wr_to_buf = wr_acc & rd_mask[wr_bank];
  assign wr_direct = wr_acc & ~rd_mask[wr_bank];
  assign drain     = wbuf_valid & ~freeze & ~rd_mask[wbuf_bank];
  assign we_any    = wr_direct | drain;
  assign w_bank    = drain ? wbuf_bank : wr_bank;
  assign w_idx     = drain ? wbuf_idx  : wr_idx;
  assign w_data    = drain ? wbuf_data : wr_data;

  always_comb begin
    we_mask = '0;
    if (we_any) we_mask[w_bank] = 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    data_t mem [BANK_DEPTH];
    data_t dout;
    idx_t  rd_idx;

    assign rd_idx = (lo_bank == bank_t'(b)) ? lo_idx : hi_idx;

    // NOTE: the storage array is never reset; only the bank output register is.
    always_ff @(posedge clk) begin
      if (we_mask[b]) mem[w_idx] <= w_data;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)             dout <= '0;
      else if (rd_mask[b]) dout <= mem[rd_idx];
    end

    assign bank_dout[b] = dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      lo_sel     <= '0;
      hi_sel     <= '0;
      wbuf_valid <= 1'b0;
      wbuf_word  <= '0;
      wbuf_data  <= '0;
    end else if (!freeze) begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        lo_sel <= lo_bank;
        hi_sel <= hi_bank;
      end
      if (wr_to_buf) begin
        wbuf_valid <= 1'b1;
        wbuf_word  <= wr_word;
        wbuf_data  <= wr_data;
      end else if (drain) begin
        wbuf_valid <= 1'b0;
      end
    end
  end

`ifdef LSU_DCCM_WBUF_BYPASS_EN
  logic  byp_lo, byp_hi;
  data_t byp_data;

  // Buffer contents are captured at accept time; the buffer may drain or refill before data is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_lo   <= 1'b0;
      byp_hi   <= 1'b0;
      byp_data <= '0;
    end else if (rd_acc) begin
      byp_lo   <= hit_lo;
      byp_hi   <= hit_hi;
      byp_data <= wbuf_data;
    end
  end

  assign rd_data_lo = byp_lo ? byp_data : bank_dout[lo_sel];
  assign rd_data_hi = byp_hi ? byp_data : bank_dout[hi_sel];
`else
  assign rd_data_lo = bank_dout[lo_sel];
  assign rd_data_hi = bank_dout[hi_sel];
`endif

  wr_when_full: assert property (@(posedge clk) disable iff (rst) !(wr_en && !freeze && wbuf_valid));

endmodule

// File: tb/tb_lsu_dccm_banked_mem.sv
// Directed self-checking bench for lsu_dccm_banked_mem (8 banks, 2048 x 39b); vector table plus
// hand-written conflict, bypass/stall, freeze and reset sequences.
module tb_lsu_dccm_banked_mem;
  localparam int AW = 16;
  localparam int DW = 39;

  localparam logic [DW-1:0] A = 39'h0A_AAAA_0100;
  localparam logic [DW-1:0] B = 39'h0B_BBBB_0FFC;
  localparam logic [DW-1:0] C = 39'h0C_CCCC_1000;
  localparam logic [DW-1:0] D = 39'h0D_DDDD_0220;
  localparam logic [DW-1:0] E = 39'h0E_EEEE_0200;
  localparam logic [DW-1:0] F = 39'h0F_0F0F_0220;
  localparam logic [DW-1:0] G = 39'h01_1111_021C;
  localparam logic [DW-1:0] H = 39'h03_3333_0220;
  localparam logic [DW-1:0] J = 39'h04_4444_0220;
  localparam logic [DW-1:0] K = 39'h02_2222_0104;
  localparam logic [DW-1:0] Z = 39'h05_5555_0104;

  logic          clk = 1'b0;
  logic          rst, freeze, wr_en, rd_en, wr_ready, rd_ready, rd_valid;
  logic [AW-1:0] wr_addr, rd_addr_lo, rd_addr_hi;
  logic [DW-1:0] wr_data, rd_data_lo, rd_data_hi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_dccm_banked_mem dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_ready   (rd_ready),
    .rd_addr_lo (rd_addr_lo),
    .rd_addr_hi (rd_addr_hi),
    .rd_data_lo (rd_data_lo),
    .rd_data_hi (rd_data_hi),
    .rd_valid   (rd_valid)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic          exp_valid;
    logic [DW-1:0] exp_lo;
    logic [DW-1:0] exp_hi;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic fz, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    @(negedge clk);
    freeze = fz; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr_lo = lo; rd_addr_hi = hi;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_rd(input string name, input logic v, input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    check({name, ".valid"}, {63'd0, rd_valid}, {63'd0, v});
    check({name, ".lo"}, {25'd0, rd_data_lo}, {25'd0, lo});
    check({name, ".hi"}, {25'd0, rd_data_hi}, {25'd0, hi});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0100, A, 1'b0, 16'h0000, 16'h0000, 1'b0, '0, '0};
    vecs[1]  = '{1'b0, 16'h0000, '0, 1'b1, 16'h0100, 16'h0100, 1'b1, A, A};
    vecs[2]  = '{1'b1, 16'h0FFC, B, 1'b0, 16'h0000, 16'h0000, 1'b0, A, A};
    vecs[3]  = '{1'b1, 16'h1000, C, 1'b0, 16'h0000, 16'h0000, 1'b0, A, A};
    vecs[4]  = '{1'b1, 16'h0104, K, 1'b1, 16'h0FFC, 16'h1000, 1'b1, B, C};
    vecs[5]  = '{1'b1, 16'h0200, E, 1'b0, 16'h0000, 16'h0000, 1'b0, B, C};
    vecs[6]  = '{1'b1, 16'h021C, G, 1'b0, 16'h0000, 16'h0000, 1'b0, B, C};
    vecs[7]  = '{1'b0, 16'h0000, '0, 1'b1, 16'h0104, 16'h0104, 1'b1, K, K};
    vecs[8]  = '{1'b0, 16'h0000, '0, 1'b1, 16'h0200, 16'h0200, 1'b1, E, E};
    vecs[9]  = '{1'b0, 16'h0000, '0, 1'b1, 16'h1000, 16'h1000, 1'b1, C, C};
    vecs[10] = '{1'b0, 16'h0000, '0, 1'b0, 16'h0000, 16'h0000, 1'b0, C, C};

    rst = 1'b1; freeze = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_lo = '0; rd_addr_hi = '0;
    #12;
    check_rd("reset", 1'b0, '0, '0);
    check("reset.wr_ready", {63'd0, wr_ready}, 64'd1);
    check("reset.rd_ready", {63'd0, rd_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Table: plain writes, aligned and bank-misaligned reads, non-conflicting write beside a read.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].lo, vecs[i].hi);
      check($sformatf("vec%0d.wr_ready", i), {63'd0, wr_ready}, 64'd1);
      check($sformatf("vec%0d.rd_ready", i), {63'd0, rd_ready}, 64'd1);
      tick();
      check($sformatf("vec%0d.valid", i), {63'd0, rd_valid}, {63'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d.lo", i), {25'd0, rd_data_lo}, {25'd0, vecs[i].exp_lo});
        check($sformatf("vec%0d.hi", i), {25'd0, rd_data_hi}, {25'd0, vecs[i].exp_hi});
      end
    end

    // Same-bank read/write conflict: read wins, write buffered, drains on the next idle cycle.
    drive(1'b0, 1'b1, 16'h0220, D, 1'b1, 16'h0200, 16'h0200);
    tick();
    check_rd("t3.read", 1'b1, E, E);
    check("t3.wr_ready_full", {63'd0, wr_ready}, 64'd0);
    idle();
    tick();
    check("t3.valid_idle", {63'd0, rd_valid}, 64'd0);
    check("t3.wr_ready_drained", {63'd0, wr_ready}, 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h0220, 16'h0220);
    tick();
    check_rd("t3.readback", 1'b1, D, D);

    // Read of the buffered word, aligned.
    drive(1'b0, 1'b1, 16'h0220, F, 1'b1, 16'h0200, 16'h0200);
    tick();
    check_rd("t4.conflict", 1'b1, E, E);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h0220, 16'h0220);
`ifdef LSU_DCCM_WBUF_BYPASS_EN
    check("t4.rd_ready_byp", {63'd0, rd_ready}, 64'd1);
    tick();
    check_rd("t4.bypass", 1'b1, F, F);
`else
    check("t4.rd_ready_stall", {63'd0, rd_ready}, 64'd0);
    tick();
    check("t4.valid_stall", {63'd0, rd_valid}, 64'd0);
    check("t4.rd_ready_retry", {63'd0, rd_ready}, 64'd1);
    tick();
    check_rd("t4.retry", 1'b1, F, F);
`endif
    idle();
    tick();
    check("t4.wr_ready_end", {63'd0, wr_ready}, 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h0220, 16'h0220);
    tick();
    check_rd("t4.memory", 1'b1, F, F);

    // Misaligned read where only the hi word is buffered.
    drive(1'b0, 1'b1, 16'h0220, H, 1'b1, 16'h0200, 16'h0200);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h021C, 16'h0220);
`ifdef LSU_DCCM_WBUF_BYPASS_EN
    tick();
    check_rd("t4b.bypass", 1'b1, G, H);
`else
    check("t4b.rd_ready_stall", {63'd0, rd_ready}, 64'd0);
    tick();
    check("t4b.valid_stall", {63'd0, rd_valid}, 64'd0);
    tick();
    check_rd("t4b.retry", 1'b1, G, H);
`endif
    idle();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h021C, 16'h0220);
    tick();
    check_rd("t4b.memory", 1'b1, G, H);

    // Freeze holds outputs and blocks all bank activity.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h0FFC, 16'h1000);
    tick();
    check_rd("t5.read", 1'b1, B, C);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0104, Z, 1'b1, 16'h0100, 16'h0100);
      check($sformatf("t5.frz%0d.wr_ready", i), {63'd0, wr_ready}, 64'd0);
      check($sformatf("t5.frz%0d.rd_ready", i), {63'd0, rd_ready}, 64'd0);
      tick();
      check_rd($sformatf("t5.frz%0d", i), 1'b1, B, C);
    end
    idle();
    tick();
    check("t5.valid_after", {63'd0, rd_valid}, 64'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h0104, 16'h0104);
    tick();
    check_rd("t5.no_write", 1'b1, K, K);

    // Reset while the buffer holds a write: outputs clear at once, buffered word is lost.
    drive(1'b0, 1'b1, 16'h0220, J, 1'b1, 16'h0200, 16'h0200);
    tick();
    check_rd("t6.before", 1'b1, E, E);
    check("t6.wr_ready_full", {63'd0, wr_ready}, 64'd0);
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check_rd("t6.async", 1'b0, '0, '0);
    check("t6.wr_ready_rst", {63'd0, wr_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6.wr_ready", {63'd0, wr_ready}, 64'd1);
    check("t6.valid", {63'd0, rd_valid}, 64'd0);
    idle();
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 16'h0220, 16'h0220);
    tick();
    check_rd("t6.discarded", 1'b1, H, H);

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
